// File: rtl/fp_pack_out.sv
// Packs FloPoCo-format results {exc, sign, exp, frac} into IEEE-style {sign, exp, frac} words
// through an elastic 2-stage pipeline. Optional exception counters under FP_PACK_EXC_COUNT_EN.
module fp_pack_out #(
    parameter int WE = 11,
    parameter int WF = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WE+WF+2:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WE+WF:0]    out_data,
    output logic [2:0]        out_flags
`ifdef FP_PACK_EXC_COUNT_EN
    ,
    input  logic              clr_cnt,
    output logic [15:0]       cnt_nan,
    output logic [15:0]       cnt_ovf,
    output logic [15:0]       cnt_uf
`endif
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_UF,
        CLS_OVF,
        CLS_INF,
        CLS_NAN
    } cls_t;

    logic [1:0]    in_exc;
    logic          in_sign;
    logic [WE-1:0] in_exp;
    logic [WF-1:0] in_frac;

    assign in_exc  = in_data[WE+WF+2 -: 2];
    assign in_sign = in_data[WE+WF];
    assign in_exp  = in_data[WF +: WE];
    assign in_frac = in_data[WF-1:0];

    cls_t          s1_cls_reg, s1_cls_next;
    logic          s1_valid_reg;
    logic          s1_sign_reg;
    logic [WE-1:0] s1_exp_reg;
    logic [WF-1:0] s1_frac_reg;

    logic          s2_valid_reg;
    logic [WE+WF:0] s2_data_reg, s2_data_next;
    logic [2:0]    s2_flags_reg, s2_flags_next;

    logic s1_load;
    logic s2_load;

    assign s2_load  = !s2_valid_reg | out_ready;
    assign s1_load  = !s1_valid_reg | s2_load;
    assign in_ready = s1_load;

    // Stage 1: classify the incoming word; exponent range edges become their own classes.
    always_comb begin
        s1_cls_next = CLS_ZERO;
        case (in_exc)
            2'b00: s1_cls_next = CLS_ZERO;
            2'b01: begin
                if (in_exp == '0)
                    s1_cls_next = CLS_UF;
                else if (in_exp == '1)
                    s1_cls_next = CLS_OVF;
                else
                    s1_cls_next = CLS_NORM;
            end
            2'b10: s1_cls_next = CLS_INF;
            default: s1_cls_next = CLS_NAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_cls_reg   <= CLS_ZERO;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_frac_reg  <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_cls_reg  <= s1_cls_next;
                s1_sign_reg <= in_sign;
                s1_exp_reg  <= in_exp;
                s1_frac_reg <= in_frac;
            end
        end
    end

    // Stage 2: pack the classified word; NaN is canonicalised and loses its sign.
    always_comb begin
        s2_data_next  = '0;
        s2_flags_next = 3'b000;
        case (s1_cls_reg)
            CLS_NORM: s2_data_next = {s1_sign_reg, s1_exp_reg, s1_frac_reg};
            CLS_UF: begin
                s2_data_next  = {s1_sign_reg, {WE{1'b0}}, {WF{1'b0}}};
                s2_flags_next = 3'b001;
            end
            CLS_OVF: begin
                s2_data_next  = {s1_sign_reg, {WE{1'b1}}, {WF{1'b0}}};
                s2_flags_next = 3'b010;
            end
            CLS_INF: s2_data_next = {s1_sign_reg, {WE{1'b1}}, {WF{1'b0}}};
            CLS_NAN: begin
                s2_data_next  = {1'b0, {WE{1'b1}}, 1'b1, {(WF-1){1'b0}}};
                s2_flags_next = 3'b100;
            end
            default: s2_data_next = {s1_sign_reg, {WE{1'b0}}, {WF{1'b0}}};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_flags_reg <= 3'b000;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg  <= s2_data_next;
                s2_flags_reg <= s2_flags_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_flags = s2_flags_reg;

`ifdef FP_PACK_EXC_COUNT_EN
    logic [2:0] count_hit;
    assign count_hit = {3{s2_valid_reg & out_ready}} & s2_flags_reg;

    // One saturating counter per flag bit; index matches out_flags {nan, ovf, uf}.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (clr_cnt)
                    cnt_reg <= '0;
                else if (count_hit[gi] && cnt_reg != 16'hFFFF)
                    cnt_reg <= cnt_reg + 16'd1;
            end
        end
    endgenerate

    assign cnt_nan = g_cnt[2].cnt_reg;
    assign cnt_ovf = g_cnt[1].cnt_reg;
    assign cnt_uf  = g_cnt[0].cnt_reg;
`endif

endmodule

// File: tb/tb_fp_pack_out.sv
// Directed bench for fp_pack_out: conversion table, backpressure, mid-stream reset and,
// when FP_PACK_EXC_COUNT_EN is defined, the exception counters.
module tb_fp_pack_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] out_data;
    logic [2:0]  out_flags;
`ifdef FP_PACK_EXC_COUNT_EN
    logic        clr_cnt;
    logic [15:0] cnt_nan, cnt_ovf, cnt_uf;
`endif

    int n_pass = 0;
    int n_total = 0;

    fp_pack_out #(.WE(11), .WF(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
`ifdef FP_PACK_EXC_COUNT_EN
        ,
        .clr_cnt   (clr_cnt),
        .cnt_nan   (cnt_nan),
        .cnt_ovf   (cnt_ovf),
        .cnt_uf    (cnt_uf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [30:0] din;
        logic [28:0] dout;
        logic [2:0]  flags;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    logic [30:0] bp_in[5];
    logic [28:0] bp_out[5];
    logic [28:0] got_q[$];

    initial begin
        vecs[0] = '{"one",      31'h27FE0000, 29'h07FE0000, 3'b000};
        vecs[1] = '{"negzero",  31'h10000000, 29'h10000000, 3'b000};
        vecs[2] = '{"neginf",   31'h5FFE0000, 29'h1FFE0000, 3'b000};
        vecs[3] = '{"nan",      31'h7FFE1234, 29'h0FFF0000, 3'b100};
        vecs[4] = '{"underflow",31'h30000ABC, 29'h10000000, 3'b001};
        vecs[5] = '{"overflow", 31'h2FFE0000, 29'h0FFE0000, 3'b010};
        vecs[6] = '{"neg_frac", 31'h3801ABCD, 29'h1801ABCD, 3'b000};
        vecs[7] = '{"exp_min",  31'h2003FFFF, 29'h0003FFFF, 3'b000};
        vecs[8] = '{"exp_max",  31'h2FFC0005, 29'h0FFC0005, 3'b000};
        vecs[9] = '{"posinf_junk", 31'h400A0077, 29'h0FFE0000, 3'b000};
        for (int k = 0; k < 5; k++) begin
            bp_in[k]  = 31'h27FE0000 | 31'(k + 1);
            bp_out[k] = 29'h07FE0000 | 29'(k + 1);
        end

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
`ifdef FP_PACK_EXC_COUNT_EN
        clr_cnt = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;
        tick();
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // Table: one word at a time, checking the 2-cycle latency exactly.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = vecs[i].din;
            out_ready = 1'b1;
            #1;
            check({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            #1;
            check({vecs[i].name, " latency"}, 32'(out_valid), 32'd0);
            tick();
            #1;
            check({vecs[i].name, " out_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, " out_data"}, 32'(out_data), 32'(vecs[i].dout));
            check({vecs[i].name, " out_flags"}, 32'(out_flags), 32'(vecs[i].flags));
            $display("vec %s: in=%08h out=%07h flags=%03b", vecs[i].name, vecs[i].din, out_data, out_flags);
        end
        tick();

        // Backpressure: out_ready low for cycles 0..5, then high.
        begin
            int sent = 0;
            int first_cyc = -1;
            int last_cyc = -1;
            got_q.delete();
            for (int cyc = 0; cyc < 40 && got_q.size() < 5; cyc++) begin
                logic acc;
                out_ready = (cyc >= 6);
                in_valid = (sent < 5);
                in_data = (sent < 5) ? bp_in[sent] : '0;
                #1;
                if (cyc >= 2 && cyc < 6) begin
                    check("bp hold valid", 32'(out_valid), 32'd1);
                    check("bp hold data", 32'(out_data), 32'(bp_out[0]));
                end
                if (cyc == 5) begin
                    check("bp accepted", 32'(sent), 32'd2);
                    check("bp in_ready low", 32'(in_ready), 32'd0);
                end
                acc = in_valid & in_ready;
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    $display("bp out word %0d: %07h at cycle %0d", got_q.size() - 1, out_data, cyc);
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
                tick();
                if (acc) sent++;
            end
            in_valid = 1'b0;
            check("bp count", 32'(got_q.size()), 32'd5);
            for (int k = 0; k < 5 && k < got_q.size(); k++)
                check("bp order", 32'(got_q[k]), 32'(bp_out[k]));
            check("bp throughput", 32'(last_cyc - first_cyc), 32'd4);
        end

`ifdef FP_PACK_EXC_COUNT_EN
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data = (k < 3) ? 31'h7FFE1234 : 31'h2FFE0000;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("cnt_nan", 32'(cnt_nan), 32'd3);
        check("cnt_ovf", 32'(cnt_ovf), 32'd1);
        check("cnt_uf", 32'(cnt_uf), 32'd0);
        $display("counters: nan=%0d ovf=%0d uf=%0d", cnt_nan, cnt_ovf, cnt_uf);
        in_valid = 1'b1;
        in_data = 31'h7FFE1234;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr out_valid", 32'(out_valid), 32'd1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr cnt_nan", 32'(cnt_nan), 32'd0);
        check("clr cnt_ovf", 32'(cnt_ovf), 32'd0);
        tick();
`endif

        // Reset with both stages full.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data = bp_in[k];
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("full before rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_data", 32'(out_data), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        begin
            int stale = 0;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (out_valid) stale++;
            end
            check("no stale word", 32'(stale), 32'd0);
        end
        in_valid = 1'b1;
        in_data = bp_in[4];
        tick();
        in_valid = 1'b0;
        tick();
        check("after rst valid", 32'(out_valid), 32'd1);
        check("after rst data", 32'(out_data), 32'(bp_out[4]));
        $display("post-reset word: %07h", out_data);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
